// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the serial shift unit: default widths, operation
// codes (shifts and rotates), the control FSM state encoding and a helper
// that tells whether an op code performs a bit step at all.
// No ports (package).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SLA = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Codes 110/111 have no step rule; the operand passes through untouched.
  function automatic logic op_is_defined(input logic [2:0] op);
    return (op <= 3'b101);
  endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-bit step of a shift or rotate.
// Ports:
//   op     in  [2:0]        operation code (shift_pkg::shift_op_e values)
//   value  in  [WIDTH-1:0]  current working value (signed)
//   result out [WIDTH-1:0]  value after one 1-bit step (signed)
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic        [2:0]       op,
  input  logic signed [WIDTH-1:0] value,
  output logic signed [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    case (op)
      OP_SLL, OP_SLA: result = {value[WIDTH-2:0], 1'b0};
      OP_SRL:         result = {1'b0, value[WIDTH-1:1]};
      OP_SRA:         result = {value[WIDTH-1], value[WIDTH-1:1]};
      OP_ROL:         result = {value[WIDTH-2:0], value[WIDTH-1]};
      OP_ROR:         result = {value[0], value[WIDTH-1:1]};
      default:        result = value;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// -----------------------------------------------------------------------------
// serial_shift_unit
// Bit-serial shifter/rotator: accepts one request, steps the operand one bit
// per enabled clock, then presents the result until the consumer takes it.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   enable     in   freezes all state when low
//   in_valid   in   request present
//   in_ready   out  unit can accept (IDLE and enable high)
//   in_data    in   [WIDTH-1:0] signed operand
//   in_amount  in   [AMT_W-1:0] distance 0..WIDTH-1
//   in_op      in   [2:0] operation code
//   out_valid  out  result present (DONE)
//   out_ready  in   consumer accepts result
//   out_data   out  [WIDTH-1:0] signed result
// -----------------------------------------------------------------------------
module serial_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic        [AMT_W-1:0] in_amount,
  input  logic        [2:0]       in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);

  state_e                  state;
  logic signed [WIDTH-1:0] work;
  logic        [AMT_W-1:0] count;
  logic        [2:0]       op;
  logic signed [WIDTH-1:0] stepped;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (op),
    .value  (work),
    .result (stepped)
  );

  assign in_ready  = (state == ST_IDLE) && enable;
  assign out_valid = (state == ST_DONE);
  assign out_data  = work;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      work  <= '0;
      count <= '0;
      op    <= OP_SLL;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            count <= in_amount;
            op    <= in_op;
            // Nothing to step: result is the operand itself, one clock later.
            if ((in_amount == '0) || !op_is_defined(in_op))
              state <= ST_DONE;
            else
              state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work  <= stepped;
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1))
            state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
module tb_serial_shift_unit;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic        [AMT_W-1:0] in_amount;
  logic        [2:0]       in_op;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  serial_shift_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Whole-distance reference result, computed directly rather than bit by bit.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d, input int a);
    case (op)
      3'd0, 3'd1: return d << a;
      3'd2:       return d >> a;
      3'd3:       return $unsigned($signed(d) >>> a);
      3'd4:       return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      3'd5:       return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
      default:    return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input int a);
    return (a == 0 || op >= 3'd6) ? 1 : a + 1;
  endfunction

  // Present a request, wait for acceptance, push the expectation.
  // Returns #1 after the accept edge (latency count 1 at that point).
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                      input logic [31:0] exp_d, input int exp_l);
    int w;
    exp_t e;
    in_op     = op;
    in_data   = d;
    in_amount = a;
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clock); #1;
      w++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
      $fatal(1, "request never accepted");
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    e.data = exp_d;
    e.lat  = exp_l;
    sb.push_back(e);
  endtask

  task automatic wait_out(input int start, output int lat, output bit to);
    lat = start;
    while (!out_valid && lat < start + 200) begin
      @(posedge clock); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amount = '0; in_op = '0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 00000000", out_data); end
    enable = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_sra;
    int lat; bit to; exp_t e;
    send(3'd3, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL sra_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL sra_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_rotate;
    int lat; bit to; exp_t e;
    send(3'd4, 32'h8000_0001, 5'd1, 32'h0000_0003, 2);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL rol_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL rol_latency: got %0d want %0d", lat, e.lat); end
    send(3'd5, 32'h8000_0001, 5'd1, 32'hC000_0000, 2);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL ror_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL ror_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_zero_amount;
    int lat; bit to; exp_t e;
    send(3'd0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL zero_amt_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL zero_amt_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_passthrough;
    int lat; bit to; exp_t e;
    send(3'd6, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 1);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL pass_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL pass_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_enable_pause;
    int lat; bit to; exp_t e; bit seen;
    send(3'd2, 32'hF000_0000, 5'd4, 32'h0F00_0000, 8);
    @(posedge clock); #1;
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL pause_no_valid: out_valid seen=1 want 0"); end
    enable = 1'b1;
    wait_out(5, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL pause_data: got %h want %h", out_data, e.data); end
    n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL pause_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_enable_gate;
    bit seen;
    @(posedge clock); #1;
    enable = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; in_amount = 5'd0; in_op = 3'd0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    n_vec++; if (seen) begin n_err++; $display("FAIL gate_not_accepted: out_valid seen=1 want 0"); end
    enable = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL gate_idle: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_backpressure;
    int lat; bit to; exp_t e; bit bad; logic [31:0] hold;
    out_ready = 1'b0;
    send(3'd1, 32'h0000_00F1, 5'd3, 32'h0000_0788, 4);
    wait_out(1, lat, to);
    e = sb.pop_front();
    n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL bp_data: got %h want %h", out_data, e.data); end
    hold = out_data;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_amount = 5'($urandom_range(0, 31)); in_op = 3'($urandom_range(0, 7));
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_vec++; if (bad) begin n_err++; $display("FAIL bp_hold: out_valid=%0b out_data=%h in_ready=%0b want 1/%h/0", out_valid, out_data, in_ready, hold); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %0b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_busy;
    exp_t e; bit seen;
    send(3'd0, 32'h0000_0001, 5'd20, 32'h0010_0000, 21);
    e = sb.pop_front();
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstbusy_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rstbusy_data: got %h want 00000000", out_data); end
    enable = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstbusy_ready: got %0b want 0", in_ready); end
    enable = 1'b1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen || out_data !== 32'h0) begin n_err++; $display("FAIL rstbusy_no_result: seen=%0b out_data=%h want 0/00000000", seen, out_data); end
  endtask

  task automatic test_back_to_back;
    int lat; bit to; exp_t e;
    logic [2:0] op; logic [31:0] d; int a;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      a  = $urandom_range(0, 31);
      if (i == 0) a = 0;
      send(op, d, 5'(a), model(op, d, a), model_lat(op, a));
      // Busy-time inputs must be ignored.
      in_valid = 1'b1; in_data = $urandom; in_amount = 5'($urandom_range(0, 31)); in_op = 3'($urandom_range(0, 7));
      wait_out(1, lat, to);
      in_valid = 1'b0;
      e = sb.pop_front();
      n_vec++; if (to || out_data !== e.data) begin n_err++; $display("FAIL b2b_data[%0d] op=%0d amt=%0d: got %h want %h", i, op, a, out_data, e.data); end
      n_vec++; if (lat != e.lat) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_rotate();
    test_zero_amount();
    test_passthrough();
    test_enable_pause();
    test_enable_gate();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_shift_unit.md
SERIAL_SHIFT_UNIT -- requirements
Module: serial_shift_unit

Interface
REQ-001 SHALL use parameter WIDTH, default 32, as the data width in bits.
REQ-002 SHALL use parameter AMT_W, default 5, as the shift-amount width in bits (log2 WIDTH).
REQ-003 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: when low, freezes all state (no accept, no step, no output change).
REQ-006 SHALL have port in_valid, input, 1 bit: request present.
REQ-007 SHALL have port in_ready, output, 1 bit: unit can accept a request.
REQ-008 SHALL have port in_data, input, WIDTH bits: signed operand.
REQ-009 SHALL have port in_amount, input, AMT_W bits: shift/rotate distance, 0..WIDTH-1.
REQ-010 SHALL have port in_op, input, 3 bits: operation code from the shared package.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port out_data, output, WIDTH bits: signed result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-015 SHALL assert in_ready only in IDLE with enable high; a request is accepted on a clock edge where in_valid and in_ready are both high.
REQ-016 SHALL, on accept, latch in_data into a working register, in_amount into a down-counter and in_op into an op register, then go to BUSY; if in_amount is 0 or in_op is undefined, SHALL go to DONE instead.
REQ-017 SHALL, in BUSY with enable high, apply one 1-bit step to the working register per clock and decrement the counter, moving to DONE on the step where the counter reaches 0.
REQ-018 SHALL support these op codes and one-bit step rules:
- 000 SLL: shift left, zero fill.
- 001 SLA: identical to SLL.
- 010 SRL: shift right, zero fill.
- 011 SRA: shift right, MSB replicated.
- 100 ROL: rotate left, MSB to LSB.
- 101 ROR: rotate right, LSB to MSB.
- 110/111: pass through unchanged.
REQ-019 SHALL assert out_valid exactly in DONE, with out_data equal to the working register; out_data SHALL be held stable while out_valid is high and out_ready is low.
REQ-020 SHALL return from DONE to IDLE on the edge where out_valid and out_ready are both high; in_ready SHALL rise the cycle after that handshake (no same-cycle turnaround).
REQ-021 SHALL have a latency, with enable constantly high, of in_amount+1 clocks from accept to out_valid, or 1 clock when in_amount is 0.
REQ-022 SHALL treat in_valid with enable low as not accepted; BUSY steps SHALL pause with enable low and resume with the counter unchanged.
REQ-023 SHALL ignore in_valid, in_data, in_amount and in_op outside IDLE.

Reset
REQ-024 SHALL, on reset low, asynchronously force state IDLE, working register 0, counter 0 and op 000, giving out_valid=0, in_ready=0 while enable is low, and out_data=0.
REQ-025 SHALL, on reset asserted mid-BUSY or in DONE, abandon the operation; no result SHALL be produced after reset deasserts.

Structure
REQ-026 SHALL take op codes (including the rotate codes), the FSM state enum and WIDTH/AMT_W defaults from shared package shift_pkg, whose existing shift codes are unchanged.
REQ-027 SHALL implement the 1-bit step in a combinational sub-module shift_step (inputs op and value, output stepped value), instantiated once.

Verification
REQ-028 SHALL be verified with SRA, in_data=0x80000000, amount=31 -> out_data=0xFFFFFFFF, out_valid 32 clocks after accept.
REQ-029 SHALL be verified with ROL, in_data=0x80000001, amount=1 -> out_data=0x00000003 after 2 clocks; and ROR with the same operand and amount -> 0xC0000000.
REQ-030 SHALL be verified with SLL, in_data=0x12345678, amount=0 -> out_data=0x12345678 with out_valid 1 clock after accept.
REQ-031 SHALL be verified with SRL, in_data=0xF0000000, amount=4, enable low for 3 clocks mid-BUSY -> out_data=0x0F000000 with latency 5+3 clocks.
REQ-032 SHALL be verified with out_ready held low 10 clocks in DONE -> out_valid and out_data stable and in_ready low throughout; in_ready high 1 clock after the handshake.
REQ-033 SHALL be verified with reset pulsed low during BUSY of SLL amount=20 -> immediate IDLE, all outputs 0, no out_valid afterwards.
